// File: rtl/mito_pkg.sv
// Shared types and helpers for the layer sequencer.
package mito_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } seq_state_t;

  // Counter width for a dimension of size n; never below one bit.
  function automatic int cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tile_counter.sv
// Nested wrap counter over a tile grid: col fastest, then row, then channel.
module tile_counter
  import mito_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int CH   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inc,
  input  logic                clr,
  output logic [cw(ROWS)-1:0] row,
  output logic [cw(COLS)-1:0] col,
  output logic [cw(CH)-1:0]   ch,
  output logic                last
);

  localparam int RW = cw(ROWS);
  localparam int CW = cw(COLS);
  localparam int HW = cw(CH);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
  localparam logic [HW-1:0] CH_MAX  = HW'(CH - 1);

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [HW-1:0] r_ch;
  logic          w_col_wrap, w_row_wrap, w_ch_max;

  assign w_col_wrap = (r_col == COL_MAX);
  assign w_row_wrap = (r_row == ROW_MAX);
  assign w_ch_max   = (r_ch == CH_MAX);

  // The channel never wraps: the owner stops incrementing once last is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
      r_ch  <= '0;
    end else if (clr) begin
      r_row <= '0;
      r_col <= '0;
      r_ch  <= '0;
    end else if (inc) begin
      if (w_col_wrap) begin
        r_col <= '0;
        if (w_row_wrap) begin
          r_row <= '0;
          r_ch  <= r_ch + 1'b1;
        end else begin
          r_row <= r_row + 1'b1;
        end
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign row  = r_row;
  assign col  = r_col;
  assign ch   = r_ch;
  assign last = w_col_wrap & w_row_wrap & w_ch_max;

endmodule

// File: rtl/layer_sequencer.sv
// Walks a conv layer tile by tile on a start edge, handshaking each tile with the PE array.
module layer_sequencer
  import mito_pkg::*;
#(
  parameter int OUT_ROWS = 4,
  parameter int OUT_COLS = 4,
  parameter int OUT_CH   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_signal,
  input  logic                    pe_ready,
  input  logic                    pe_done,
  output logic                    pe_valid,
  output logic [cw(OUT_ROWS)-1:0] tile_row,
  output logic [cw(OUT_COLS)-1:0] tile_col,
  output logic [cw(OUT_CH)-1:0]   tile_ch,
  output logic                    busy,
  output logic                    done
);

  seq_state_t r_state, w_next;
  logic       r_start_q;
  logic       w_start_rise, w_inc, w_clr, w_last;

  assign w_start_rise = start_signal & ~r_start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_start_q <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_start_q <= start_signal;
    end
  end

  always_comb begin
    w_next = r_state;
    w_inc  = 1'b0;
    w_clr  = 1'b0;
    case (r_state)
      IDLE: begin
        w_clr = 1'b1;
        if (w_start_rise) w_next = ISSUE;
      end
      ISSUE: begin
        if (pe_ready) w_next = WAIT;
      end
      WAIT: begin
        if (pe_done) begin
          if (w_last) begin
            w_next = FINISH;
          end else begin
            w_inc  = 1'b1;
            w_next = ISSUE;
          end
        end
      end
      FINISH: begin
        w_clr  = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  tile_counter #(
    .ROWS (OUT_ROWS),
    .COLS (OUT_COLS),
    .CH   (OUT_CH)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_inc),
    .clr   (w_clr),
    .row   (tile_row),
    .col   (tile_col),
    .ch    (tile_ch),
    .last  (w_last)
  );

  // Outputs decode from state only, so no input reaches an output combinationally.
  assign pe_valid = (r_state == ISSUE);
  assign busy     = (r_state != IDLE);
  assign done     = (r_state == FINISH);

endmodule

// File: tb/tb_layer_sequencer.sv
// Randomized bench for layer_sequencer against a tile-order transaction model.
module tb_layer_sequencer;

  localparam int R = 4, C = 4, H = 2;
  localparam int N = R * C * H;

  logic       clk = 1'b0;
  logic       rst_n, start_signal, pe_ready, pe_done;
  logic       pe_valid, busy, done;
  logic [1:0] tile_row, tile_col;
  logic [0:0] tile_ch;

  logic       start_b, ready_b, pdone_b;
  logic       valid_b, busy_b, done_b;
  logic [0:0] row_b, col_b, ch_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  layer_sequencer #(.OUT_ROWS(R), .OUT_COLS(C), .OUT_CH(H)) dut (
    .clk(clk), .rst_n(rst_n), .start_signal(start_signal), .pe_ready(pe_ready),
    .pe_done(pe_done), .pe_valid(pe_valid), .tile_row(tile_row), .tile_col(tile_col),
    .tile_ch(tile_ch), .busy(busy), .done(done)
  );

  layer_sequencer #(.OUT_ROWS(1), .OUT_COLS(1), .OUT_CH(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_signal(start_b), .pe_ready(ready_b),
    .pe_done(pdone_b), .pe_valid(valid_b), .tile_row(row_b), .tile_col(col_b),
    .tile_ch(ch_b), .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, pe_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_coord"}, {tile_ch, tile_row, tile_col}, 0);
  endtask

  // PE-side model: tile idx maps to (ch,row,col) by plain arithmetic; the bench
  // decides ready/done each cycle and predicts what the sequencer must show.
  task automatic run_layer(input bit pre, input int rdy_pct, input int max_dly,
                           input int spur_pct, input int bp_idx, input int abort_idx,
                           input bit chk_time);
    int idx = 0, n = 0, wcnt = 0, bp = 0;
    bit iss = 1'b1, fin = 1'b0, ended = 1'b0;
    if (!pre) begin
      start_signal = 1'b0; pe_ready = 1'b0; pe_done = 1'b0;
      @(negedge clk);
      start_signal = 1'b1;
    end
    while (n < 3000 && !ended) begin
      @(negedge clk);
      n++;
      if (fin) begin
        chk("done_pulse", done, 1);
        chk("busy_fin", busy, 1);
        chk("valid_fin", pe_valid, 0);
        if (chk_time) chk("done_cycle", n, 2 * N + 1);
        pe_done = 1'b1;
        @(negedge clk);
        chk("busy_after", busy, 0);
        chk("done_after", done, 0);
        pe_done = 1'b0;
        ended = 1'b1;
      end else begin
        chk("busy", busy, 1);
        chk("done_early", done, 0);
        chk("valid", pe_valid, int'(iss));
        if (iss) begin
          chk("col", tile_col, idx % C);
          chk("row", tile_row, (idx / C) % R);
          chk("ch", tile_ch, idx / (R * C));
          if (idx == abort_idx) begin
            rst_n = 1'b0;
            return;
          end
          if (idx == bp_idx && bp < 5) begin
            pe_ready = 1'b0;
            pe_done  = 1'b1;
            bp++;
          end else begin
            pe_ready = ($urandom_range(99) < rdy_pct);
            pe_done  = ($urandom_range(99) < spur_pct);
          end
          if (pe_ready) begin
            iss  = 1'b0;
            wcnt = (idx == bp_idx) ? 7 : int'($urandom_range(max_dly));
          end
        end else begin
          pe_ready = ($urandom_range(99) < rdy_pct);
          if (wcnt == 0) begin
            pe_done = 1'b1;
            if (idx == N - 1) fin = 1'b1;
            else begin
              idx++;
              iss = 1'b1;
            end
          end else begin
            pe_done = 1'b0;
            wcnt--;
          end
        end
      end
    end
    chk("run_completed", int'(ended), 1);
  endtask

  initial begin
    rst_n = 1'b0; start_signal = 1'b0; pe_ready = 1'b0; pe_done = 1'b0;
    start_b = 1'b0; ready_b = 1'b1; pdone_b = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle("in_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_idle("idle");
      chk("b_idle_busy", busy_b, 0);
    end

    // Back-to-back tiles, then a held start level must not retrigger.
    pe_ready = 1'b1; pe_done = 1'b1;
    run_layer(1'b0, 100, 0, 100, -1, -1, 1'b1);
    pe_ready = 1'b1; pe_done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("held_busy", busy, 0);
      chk("held_valid", pe_valid, 0);
    end

    // Backpressure with spurious done on tile (0,1,2), then 7-cycle completion.
    run_layer(1'b0, 100, 0, 0, 6, -1, 1'b0);

    for (int r = 0; r < 3; r++) run_layer(1'b0, 60, 7, 30, -1, -1, 1'b0);

    // Reset while tile (1,0,0) is offered, start level held high throughout.
    run_layer(1'b0, 80, 2, 20, -1, 16, 1'b0);
    #1;
    chk_idle("rst_now");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_idle("rst_hold");
    end
    rst_n = 1'b1;
    pe_ready = 1'b1; pe_done = 1'b1;
    run_layer(1'b1, 100, 0, 100, -1, -1, 1'b1);

    // Degenerate 1x1x1 layer: rise sampled at edge k, done in cycle k+3.
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    chk("b_issue_valid", valid_b, 1);
    chk("b_issue_coord", {ch_b, row_b, col_b}, 0);
    chk("b_issue_busy", busy_b, 1);
    @(negedge clk);
    chk("b_wait_valid", valid_b, 0);
    chk("b_wait_done", done_b, 0);
    @(negedge clk);
    chk("b_done", done_b, 1);
    chk("b_fin_busy", busy_b, 1);
    @(negedge clk);
    chk("b_after_busy", busy_b, 0);
    chk("b_after_done", done_b, 0);
    chk("b_after_valid", valid_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Consumes the sticky start level from the top-level controller and walks a convolution layer tile by tile: output column fastest, then row, then output channel. For each tile it issues coordinates to the PE array over a valid/ready handshake and waits for the array's completion pulse. After the last tile it raises a one-cycle `done` pulse. This is the receive end of the start interface: the controller sets `start_signal`, and this block acts on it.

## Interface
- `OUT_ROWS`, default 4: output feature-map rows, ≥1
- `OUT_COLS`, default 4: output feature-map columns, ≥1
- `OUT_CH`, default 2: output channels, ≥1
- `clk`  in  1: single clock, rising edge
- `rst_n`  in  1: reset; one clock, asynchronous, active-low
- `start_signal`  in  1: sticky start level from the controller
- `pe_ready`  in  1: PE array can accept a tile
- `pe_done`  in  1: one-cycle pulse, issued tile finished
- `pe_valid`  out  1: tile coordinates valid
- `tile_row`  out  $clog2(OUT_ROWS) (min 1): current tile row
- `tile_col`  out  $clog2(OUT_COLS) (min 1): current tile column
- `tile_ch`  out  $clog2(OUT_CH) (min 1): current output channel
- `busy`  out  1: high in every state except IDLE
- `done`  out  1: one-cycle pulse at layer completion

## Operation
- Start detection
  - `start_q` registers `start_signal`.
  - `start_rise = start_signal & ~start_q`.
  - A run begins only on `start_rise`. A level held high after a run does not retrigger.
- States: IDLE, ISSUE, WAIT, FINISH.
- IDLE
  - Counters held at 0.
  - On `start_rise`, go to ISSUE; otherwise stay.
- ISSUE
  - `pe_valid`=1, coordinates driven from the counters.
  - Transfer occurs when `pe_valid & pe_ready`; then go to WAIT.
  - Coordinates stay stable while `pe_ready`=0.
  - `pe_done` is ignored in ISSUE.
- WAIT
  - `pe_valid`=0.
  - On `pe_done` at the last tile (row, col, ch all at max), go to FINISH.
  - On `pe_done` otherwise, advance the counters and go to ISSUE.
  - Without `pe_done`, stay.
- Counter advance
  - `col` increments. At `OUT_COLS-1` it wraps to 0 and `row` increments.
  - `row` wraps at `OUT_ROWS-1` and `ch` increments.
  - `ch` never wraps within a run.
- FINISH: `done`=1 for exactly this cycle, counters cleared to 0, then IDLE.
- A `start_rise` arriving in any non-IDLE state is ignored; there is no queuing.
- `pe_done` in IDLE or FINISH is ignored.
- Degenerate 1×1×1 layer: ISSUE → WAIT → FINISH.

## Timing
- Reset values: state=IDLE, `start_q`=0, all counters 0, `pe_valid`=0, `busy`=0, `done`=0.
- All outputs are registered, or decoded only from state and counters; no input-to-output combinational paths.
- A rising edge sampled at edge k puts the block in ISSUE in cycle k+1.
- Minimum time per tile is 2 cycles: ISSUE with `pe_ready`=1, then WAIT with `pe_done`=1.
- With `pe_ready` and `pe_done` held at 1, `done` is high in cycle k+2N+1, where N=`OUT_ROWS*OUT_COLS*OUT_CH`. `busy` is high in cycles k+1 through k+2N+1.
- Reset asserted mid-run: immediately returns to reset values; no `done` is emitted.
- After reset deasserts, `start_q`=0. If `start_signal` is already 1, the next edge sees a rising edge and a new run starts.

## Structure
- Package `mito_pkg`:
  - `seq_state_t` enum (IDLE, ISSUE, WAIT, FINISH)
  - helper function `cw(n)` returning `max(1, $clog2(n))`
- Sub-module `tile_counter`:
  - Nested wrap counter with parameters ROWS/COLS/CH.
  - Inputs: `inc`, `clr`.
  - Outputs: `row`, `col`, `ch`, `last`.
- The FSM and start-edge detect live in `layer_sequencer`.

## Test plan
- Reset and idle
  - Stimulus: `rst_n` low, then high, `start_signal`=0 for 10 cycles.
  - Response: all outputs 0 and `busy`=0 throughout.
- Full run, defaults, `pe_ready`=`pe_done`=1
  - Stimulus: `start_signal` rises at edge k.
  - Response: 32 issues in order (ch,row,col) = (0,0,0),(0,0,1)…(1,3,3).
  - Response: `done` pulse in cycle k+65; `busy` high k+1..k+65.
  - Response: no second run while `start_signal` stays 1.
- Backpressure
  - Stimulus: `pe_ready` low for 5 cycles during tile (0,1,2).
  - Response: `pe_valid` held high and coordinates stable; exactly one transfer.
- Delayed completion
  - Stimulus: `pe_done` arrives 7 cycles after the transfer.
  - Response: stays in WAIT with `pe_valid`=0.
  - Stimulus: spurious `pe_done` during ISSUE.
  - Response: no counter advance.
- Reset mid-run
  - Stimulus: `rst_n` low at tile (1,0,0) with `start_signal` held 1.
  - Response: outputs cleared, no `done`.
  - Response: after release, a new run starts at (0,0,0) one edge later.
- Degenerate 1×1×1
  - Stimulus: start.
  - Response: single issue of (0,0,0); `done` at k+3.
